// File: rtl/imem_wb_bridge.sv
// -----------------------------------------------------------------------------
// imem_wb_bridge
//   Wishbone B4 classic single-beat slave in front of port 2 of the
//   instruction memory. A bus read becomes a fixed-latency port-2 read and a
//   bus write becomes a port-2 byte-enabled write. Out-of-range, misaligned
//   and (when WRITE_EN == 0) write accesses are answered with err.
//
// Ports
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_wb_cyc/stb/we         : bus cycle, strobe, write select
//   i_wb_adr/dat/sel        : byte address, write data, byte lanes
//   o_wb_dat/ack/err        : read data (held), one-cycle ack / err
//   o_p2_en, o_p2_addr      : memory port-2 read enable and byte offset
//   i_p2_rd                 : memory read data, valid one cycle after en
//   o_p2_we/wdata/wsel      : memory port-2 write strobe, data, byte enables
// -----------------------------------------------------------------------------
module imem_wb_bridge #(
  parameter int unsigned SIZE_BYTE = 2048,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          WRITE_EN  = 1'b1,
  localparam int unsigned ADDRWIDTH = $clog2(SIZE_BYTE - 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [31:0]          i_wb_adr,
  input  logic [31:0]          i_wb_dat,
  input  logic [3:0]           i_wb_sel,
  output logic [31:0]          o_wb_dat,
  output logic                 o_wb_ack,
  output logic                 o_wb_err,
  output logic                 o_p2_en,
  output logic [ADDRWIDTH-1:0] o_p2_addr,
  input  logic [31:0]          i_p2_rd,
  output logic                 o_p2_we,
  output logic [31:0]          o_p2_wdata,
  output logic [3:0]           o_p2_wsel
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_CAPTURE = 3'd2,
    WR_ISSUE   = 3'd3,
    ACK        = 3'd4,
    ERR        = 3'd5
  } state_t;

  state_t                 state_q;
  logic [31:0]            rdata_q;
  logic                   ack_q;
  logic                   err_q;
  logic                   p2_en_q;
  logic                   p2_we_q;
  logic [ADDRWIDTH-1:0]   p2_addr_q;
  logic [31:0]            p2_wdata_q;
  logic [3:0]             p2_wsel_q;

  logic [31:0]            offset_s;
  logic                   dec_err_s;

  // Request decode: offset wraps modulo 2^32, so addresses below BASE_ADDR
  // become huge offsets and fall into the out-of-range error.
  always_comb begin
    offset_s  = i_wb_adr - BASE_ADDR;
    dec_err_s = (offset_s >= 32'(SIZE_BYTE))
              | (i_wb_adr[1:0] != 2'b00)
              | (i_wb_we & (WRITE_EN == 1'b0));
  end

  // Bridge FSM with all outputs registered. Pulse outputs default low each
  // cycle and are set on the transition into the state that owns them.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      rdata_q    <= 32'h0000_0000;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      p2_en_q    <= 1'b0;
      p2_we_q    <= 1'b0;
      p2_addr_q  <= '0;
      p2_wdata_q <= 32'h0000_0000;
      p2_wsel_q  <= 4'b0000;
    end else begin
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      p2_en_q <= 1'b0;
      p2_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            if (dec_err_s) begin
              err_q   <= 1'b1;
              state_q <= ERR;
            end else begin
              p2_addr_q <= offset_s[ADDRWIDTH-1:0];
              if (i_wb_we) begin
                // A write with no lanes enabled still completes with ack.
                p2_we_q    <= |i_wb_sel;
                p2_wdata_q <= i_wb_dat;
                p2_wsel_q  <= i_wb_sel;
                state_q    <= WR_ISSUE;
              end else begin
                p2_en_q <= 1'b1;
                state_q <= RD_ISSUE;
              end
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RD_ISSUE: begin
          state_q <= i_wb_cyc ? RD_CAPTURE : IDLE;
        end
        RD_CAPTURE: begin
          // An aborted read leaves the held read data untouched.
          if (i_wb_cyc) begin
            rdata_q <= i_p2_rd;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            state_q <= IDLE;
          end
        end
        WR_ISSUE: begin
          // The strobe has already been driven; abort only suppresses ack.
          if (i_wb_cyc) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            state_q <= IDLE;
          end
        end
        ACK:     state_q <= IDLE;
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_wb_dat   = rdata_q;
  assign o_wb_ack   = ack_q;
  assign o_wb_err   = err_q;
  assign o_p2_en    = p2_en_q;
  assign o_p2_addr  = p2_addr_q;
  assign o_p2_we    = p2_we_q;
  assign o_p2_wdata = p2_wdata_q;
  assign o_p2_wsel  = p2_wsel_q;

endmodule
